// File: rtl/fpu_resbuf_pkg.sv
// Shared types for the FP16 FPU result buffer: status flags, entry layout, exception helper.
package fpu_resbuf_pkg;

  // Same bit order as fpnew_pkg::status_t: {NV, DZ, OF, UF, NX}.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam int EXC_CNT_W  = 16;
  localparam int RES_W      = 16;
  localparam int TAG_W_DFLT = 1;

  typedef struct packed {
    logic [RES_W-1:0]      result;
    status_t               status;
    logic [TAG_W_DFLT-1:0] tag;
  } resbuf_entry_t;

  function automatic logic any_exc(input status_t s);
    return |s;
  endfunction

endpackage

// File: rtl/fpu_resbuf_mem.sv
// Result buffer storage: DEPTH entries, one synchronous write port, one asynchronous read port.
module fpu_resbuf_mem
  import fpu_resbuf_pkg::*;
#(
  parameter int W     = 22,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [DEPTH];

  // Array is deliberately left unreset; head contents are don't-care until valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fpu_result_buffer.sv
// In-order FIFO between the FP16 FPU output and its consumer, with sticky IEEE flags.
// Optional exception counter enabled by defining FPU_RESBUF_STATS_EN.
module fpu_result_buffer
  import fpu_resbuf_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int TAG_W = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         fpu_result_i,
  input  logic [4:0]               fpu_status_i,
  input  logic [TAG_W-1:0]         fpu_tag_i,
  input  logic                     fpu_valid_i,
  output logic                     fpu_ready_o,
  output logic [WIDTH-1:0]         res_data_o,
  output logic [4:0]               res_status_o,
  output logic [TAG_W-1:0]         res_tag_o,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  input  logic                     flush_i,
  input  logic                     clr_flags_i,
  output logic [4:0]               fflags_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [EXC_CNT_W-1:0]     exc_count_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = WIDTH + 5 + TAG_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [4:0]         fflags;
  logic               push;
  logic               pop;
  logic               push_eff;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  // Ready derives only from the registered count, so consumer stalls never reach the FPU combinationally.
  assign fpu_ready_o = (count < FULL);
  assign res_valid_o = (count != {CNT_W{1'b0}});
  assign push        = fpu_valid_i & fpu_ready_o;
  assign pop         = res_valid_o & res_ready_i;
  assign push_eff    = push & ~flush_i;
  assign wr_entry    = {fpu_result_i, fpu_status_i, fpu_tag_i};

  fpu_resbuf_mem #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_eff),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign res_data_o   = rd_entry[ENTRY_W-1 -: WIDTH];
  assign res_status_o = rd_entry[TAG_W +: 5];
  assign res_tag_o    = rd_entry[TAG_W-1:0];
  assign count_o      = count;
  assign fflags_o     = fflags;

  // Pointer and occupancy tracking; flush overrides any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flags accumulate at push time; a clear in the same cycle keeps only the new status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fflags <= 5'b00000;
    end else if (clr_flags_i) begin
      fflags <= push_eff ? fpu_status_i : 5'b00000;
    end else if (push_eff) begin
      fflags <= fflags | fpu_status_i;
    end else begin
      fflags <= fflags;
    end
  end

`ifdef FPU_RESBUF_STATS_EN
  logic [EXC_CNT_W-1:0] exc_count;
  logic                 exc_push;

  assign exc_push    = push_eff & any_exc(status_t'(fpu_status_i));
  assign exc_count_o = exc_count;

  // Saturating count of exceptional pushes, restarted by a flag clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_count <= {EXC_CNT_W{1'b0}};
    end else if (clr_flags_i) begin
      exc_count <= exc_push ? EXC_CNT_W'(1) : {EXC_CNT_W{1'b0}};
    end else if (exc_push && (exc_count != {EXC_CNT_W{1'b1}})) begin
      exc_count <= exc_count + EXC_CNT_W'(1);
    end else begin
      exc_count <= exc_count;
    end
  end
`else
  assign exc_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Directed self-checking bench for fpu_result_buffer (WIDTH=16, DEPTH=4, TAG_W=1).
module tb_fpu_result_buffer;

  logic        clk;
  logic        rst;
  logic [15:0] fpu_result_i;
  logic [4:0]  fpu_status_i;
  logic [0:0]  fpu_tag_i;
  logic        fpu_valid_i;
  logic        fpu_ready_o;
  logic [15:0] res_data_o;
  logic [4:0]  res_status_o;
  logic [0:0]  res_tag_o;
  logic        res_valid_o;
  logic        res_ready_i;
  logic        flush_i;
  logic        clr_flags_i;
  logic [4:0]  fflags_o;
  logic [2:0]  count_o;
  logic [15:0] exc_count_o;

  int tests_run;
  int tests_failed;

  fpu_result_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .fpu_result_i (fpu_result_i),
    .fpu_status_i (fpu_status_i),
    .fpu_tag_i    (fpu_tag_i),
    .fpu_valid_i  (fpu_valid_i),
    .fpu_ready_o  (fpu_ready_o),
    .res_data_o   (res_data_o),
    .res_status_o (res_status_o),
    .res_tag_o    (res_tag_o),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .flush_i      (flush_i),
    .clr_flags_i  (clr_flags_i),
    .fflags_o     (fflags_o),
    .count_o      (count_o),
    .exc_count_o  (exc_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_exc;
  logic [15:0] order [5];
  logic [4:0]  st6 [5];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    fpu_result_i = 16'h0000;
    fpu_status_i = 5'b00000;
    fpu_tag_i    = 1'b0;
    fpu_valid_i  = 1'b0;
    res_ready_i  = 1'b0;
    flush_i      = 1'b0;
    clr_flags_i  = 1'b0;
    #12;
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_valid", 32'(res_valid_o), 32'd0);
    check("rst_ready", 32'(fpu_ready_o), 32'd1);
    check("rst_fflags", 32'(fflags_o), 32'd0);
    check("rst_exc", 32'(exc_count_o), 32'd0);
    rst = 1'b1;
    step();

    // Single push then pop
    res_ready_i  = 1'b1;
    fpu_valid_i  = 1'b1;
    fpu_result_i = 16'h3C00;
    fpu_tag_i    = 1'b1;
    step();
    fpu_valid_i = 1'b0;
    check("single_valid", 32'(res_valid_o), 32'd1);
    check("single_data", 32'(res_data_o), 32'h3C00);
    check("single_tag", 32'(res_tag_o), 32'd1);
    check("single_count", 32'(count_o), 32'd1);
    step();
    check("single_drain", 32'(count_o), 32'd0);
    check("single_novalid", 32'(res_valid_o), 32'd0);

    // Fill to full with consumer stalled
    fpu_tag_i   = 1'b0;
    res_ready_i = 1'b0;
    order[0] = 16'h4000; order[1] = 16'h4200; order[2] = 16'h4400;
    order[3] = 16'h4500; order[4] = 16'h4600;
    fpu_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fpu_result_i = order[i];
      step();
    end
    check("full_ready", 32'(fpu_ready_o), 32'd0);
    check("full_count", 32'(count_o), 32'd4);
    fpu_result_i = order[4];
    step();
    step();
    check("held_count", 32'(count_o), 32'd4);
    check("held_head", 32'(res_data_o), 32'h4000);
    res_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("order_valid%0d", k), 32'(res_valid_o), 32'd1);
      check($sformatf("order_data%0d", k), 32'(res_data_o), 32'(order[k]));
      step();
      if (k == 1) fpu_valid_i = 1'b0;
    end
    check("order_empty", 32'(count_o), 32'd0);

    // Sticky flags
    fpu_valid_i  = 1'b1;
    fpu_result_i = 16'h1111;
    fpu_status_i = 5'b00001;
    step();
    fpu_status_i = 5'b00101;
    step();
    fpu_valid_i = 1'b0;
    check("flags_or", 32'(fflags_o), 32'b00101);
`ifdef FPU_RESBUF_STATS_EN
    exp_exc = 16'd2;
`else
    exp_exc = 16'd0;
`endif
    check("exc_two", 32'(exc_count_o), 32'(exp_exc));
    fpu_valid_i  = 1'b1;
    clr_flags_i  = 1'b1;
    fpu_status_i = 5'b00010;
    step();
    fpu_valid_i = 1'b0;
    clr_flags_i = 1'b0;
    check("flags_clr_push", 32'(fflags_o), 32'b00010);
`ifdef FPU_RESBUF_STATS_EN
    exp_exc = 16'd1;
`else
    exp_exc = 16'd0;
`endif
    check("exc_clr_push", 32'(exc_count_o), 32'(exp_exc));
    clr_flags_i = 1'b1;
    step();
    clr_flags_i = 1'b0;
    check("flags_clr", 32'(fflags_o), 32'd0);
    check("exc_clr", 32'(exc_count_o), 32'd0);
    check("flags_drain", 32'(count_o), 32'd0);

    // Back-to-back streaming wraps pointers
    fpu_status_i = 5'b00000;
    fpu_valid_i  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fpu_result_i = 16'h5000 + 16'(i);
      step();
      check($sformatf("stream_count%0d", i), 32'(count_o), 32'd1);
      check($sformatf("stream_data%0d", i), 32'(res_data_o), 32'h5000 + 32'(i));
    end
    fpu_valid_i = 1'b0;
    step();
    check("stream_empty", 32'(count_o), 32'd0);

    // Flush with two entries; same-cycle push dropped, flags untouched
    res_ready_i = 1'b0;
    fpu_valid_i = 1'b1;
    fpu_result_i = 16'h6000;
    step();
    fpu_result_i = 16'h6001;
    step();
    check("preflush_count", 32'(count_o), 32'd2);
    flush_i      = 1'b1;
    fpu_result_i = 16'h6002;
    fpu_status_i = 5'b10000;
    step();
    flush_i     = 1'b0;
    fpu_valid_i = 1'b0;
    check("flush_count", 32'(count_o), 32'd0);
    check("flush_valid", 32'(res_valid_o), 32'd0);
    check("flush_ready", 32'(fpu_ready_o), 32'd1);
    check("flush_fflags", 32'(fflags_o), 32'd0);
    check("flush_exc", 32'(exc_count_o), 32'd0);
    fpu_valid_i  = 1'b1;
    fpu_status_i = 5'b00000;
    fpu_result_i = 16'h7777;
    step();
    fpu_valid_i = 1'b0;
    check("postflush_data", 32'(res_data_o), 32'h7777);
    check("postflush_count", 32'(count_o), 32'd1);
    res_ready_i = 1'b1;
    step();

    // Exception counter: 3 exceptional, 2 clean
    st6[0] = 5'b00001; st6[1] = 5'b00000; st6[2] = 5'b10000;
    st6[3] = 5'b00000; st6[4] = 5'b01000;
    fpu_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fpu_result_i = 16'h8000 + 16'(i);
      fpu_status_i = st6[i];
      step();
      check($sformatf("exc_status%0d", i), 32'(res_status_o), 32'(st6[i]));
    end
    fpu_valid_i = 1'b0;
`ifdef FPU_RESBUF_STATS_EN
    exp_exc = 16'd3;
`else
    exp_exc = 16'd0;
`endif
    check("exc_three", 32'(exc_count_o), 32'(exp_exc));
    check("exc_fflags", 32'(fflags_o), 32'b11001);
    step();

    // Async reset mid-run with 3 entries
    res_ready_i  = 1'b0;
    fpu_valid_i  = 1'b1;
    fpu_status_i = 5'b00100;
    for (int i = 0; i < 3; i++) begin
      fpu_result_i = 16'h9000 + 16'(i);
      step();
    end
    fpu_valid_i = 1'b0;
    check("prerst_count", 32'(count_o), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_valid", 32'(res_valid_o), 32'd0);
    check("midrst_count", 32'(count_o), 32'd0);
    check("midrst_ready", 32'(fpu_ready_o), 32'd1);
    check("midrst_fflags", 32'(fflags_o), 32'd0);
    check("midrst_exc", 32'(exc_count_o), 32'd0);
    #3;
    rst = 1'b1;
    step();
    check("postrst_count", 32'(count_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
